// File: rtl/dds_phase_accum_if.sv
// Tuning-word handshake, run controls and lookup-address outputs of the DDS phase accumulator.
interface dds_phase_accum_if #(
  parameter int ACC_W = 24,
  parameter int OUT_W = 8
) ();
  logic             en;
  logic             phase_clr;
  logic [ACC_W-1:0] ftw_data;
  logic             ftw_immediate;
  logic             ftw_valid;
  logic             ftw_ready;
  logic [OUT_W-1:0] phase_off;
  logic [ACC_W-1:0] ftw_active;
  logic [OUT_W-1:0] address;
  logic             addr_valid;
  logic             wrap;

  modport master (
    output en, phase_clr, ftw_data, ftw_immediate, ftw_valid, phase_off,
    input  ftw_ready, ftw_active, address, addr_valid, wrap
  );

  modport slave (
    input  en, phase_clr, ftw_data, ftw_immediate, ftw_valid, phase_off,
    output ftw_ready, ftw_active, address, addr_valid, wrap
  );
endinterface

// File: rtl/dds_phase_accum.sv
// DDS phase accumulator: adds the active tuning word each enabled cycle and emits the
// top bits plus a phase offset as the sine-lookup address; new words apply now or at wrap.
module dds_phase_accum #(
  parameter int ACC_W = 24,
  parameter int OUT_W = 8
) (
  input logic              i_clk,
  input logic              i_rst_n,
  dds_phase_accum_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_ftw_active;
  logic [ACC_W-1:0] r_pend;
  logic [OUT_W-1:0] r_address;
  logic             r_addr_valid;
  logic             r_wrap;
  logic             r_ftw_ready;

  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_sum;
  logic             w_xfer;
  logic             w_queue;
  logic             w_apply_pend;

  logic [ACC_W-1:0] w_acc_nxt;
  logic [ACC_W-1:0] w_ftw_nxt;
  logic [ACC_W-1:0] w_pend_nxt;
  logic [OUT_W-1:0] w_addr_nxt;
  logic             w_addr_valid_nxt;
  logic             w_wrap_nxt;
  logic             w_ready_nxt;

  assign w_sum     = {1'b0, r_acc} + {1'b0, r_ftw_active};
  assign w_carry   = w_sum[ACC_W];
  assign w_acc_sum = w_sum[ACC_W-1:0];
  assign w_xfer    = bus.ftw_valid & r_ftw_ready;
  // Only a deferred word taken while running is queued; with en low it applies at once.
  assign w_queue   = w_xfer & ~bus.ftw_immediate & bus.en;

  always_comb begin
    w_state_nxt  = r_state;
    w_apply_pend = 1'b0;
    if (r_state == S_PEND) begin
      w_apply_pend = bus.phase_clr | ~bus.en | w_carry;
    end
    if (!bus.en) begin
      w_state_nxt = S_IDLE;
    end else if (w_queue) begin
      w_state_nxt = S_PEND;
    end else if ((r_state == S_PEND) && !w_apply_pend) begin
      w_state_nxt = S_PEND;
    end else begin
      w_state_nxt = S_RUN;
    end
    w_ready_nxt = (w_state_nxt != S_PEND);
  end

  always_comb begin
    w_acc_nxt        = r_acc;
    w_addr_nxt       = r_address;
    w_addr_valid_nxt = 1'b0;
    w_wrap_nxt       = 1'b0;
    w_ftw_nxt        = r_ftw_active;
    w_pend_nxt       = r_pend;
    if (bus.phase_clr) begin
      w_acc_nxt        = '0;
      w_addr_nxt       = bus.phase_off;
      w_addr_valid_nxt = bus.en;
    end else if (bus.en) begin
      w_acc_nxt        = w_acc_sum;
      w_addr_nxt       = w_acc_sum[ACC_W-1 -: OUT_W] + bus.phase_off;
      w_wrap_nxt       = w_carry;
      w_addr_valid_nxt = 1'b1;
    end
    // The wrapping add above still uses the old word; a released word takes over after it.
    if (w_xfer && (bus.ftw_immediate || !bus.en)) begin
      w_ftw_nxt = bus.ftw_data;
    end else if (w_apply_pend) begin
      w_ftw_nxt = r_pend;
    end
    if (w_queue) begin
      w_pend_nxt = bus.ftw_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc        <= '0;
      r_ftw_active <= '0;
      r_pend       <= '0;
      r_address    <= '0;
      r_addr_valid <= 1'b0;
      r_wrap       <= 1'b0;
      r_ftw_ready  <= 1'b0;
    end else begin
      r_acc        <= w_acc_nxt;
      r_ftw_active <= w_ftw_nxt;
      r_pend       <= w_pend_nxt;
      r_address    <= w_addr_nxt;
      r_addr_valid <= w_addr_valid_nxt;
      r_wrap       <= w_wrap_nxt;
      r_ftw_ready  <= w_ready_nxt;
    end
  end

  assign bus.ftw_ready  = r_ftw_ready;
  assign bus.ftw_active = r_ftw_active;
  assign bus.address    = r_address;
  assign bus.addr_valid = r_addr_valid;
  assign bus.wrap       = r_wrap;

endmodule

// File: tb/tb_dds_phase_accum.sv
// Self-checking bench for dds_phase_accum: address/wrap stream via a scoreboard queue,
// handshake and control outputs checked inline per scenario.
module tb_dds_phase_accum;

  localparam int ACC_W = 24;
  localparam int OUT_W = 8;

  typedef struct packed {
    logic [OUT_W-1:0] addr;
    logic             wrap;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  dds_phase_accum_if #(.ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

  dds_phase_accum #(.ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every cycle that presents an address consumes one expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (bus.addr_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL addr_stream unexpected got addr=%h wrap=%b required none", bus.address, bus.wrap);
      end else begin
        e = exp_q.pop_front();
        if (bus.address !== e.addr || bus.wrap !== e.wrap) begin
          errors++;
          $display("[TB] FAIL addr_stream got addr=%h wrap=%b required addr=%h wrap=%b",
                   bus.address, bus.wrap, e.addr, e.wrap);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [OUT_W-1:0] a, input logic w);
    exp_t e;
    e.addr = a;
    e.wrap = w;
    exp_q.push_back(e);
  endtask

  task automatic load_now(input logic [ACC_W-1:0] d);
    bus.en            = 1'b0;
    bus.ftw_data      = d;
    bus.ftw_immediate = 1'b1;
    bus.ftw_valid     = 1'b1;
    tick();
    bus.ftw_valid     = 1'b0;
    bus.ftw_immediate = 1'b0;
    checks++;
    if (bus.ftw_active !== d) begin
      errors++;
      $display("[TB] FAIL load_now got %h required %h", bus.ftw_active, d);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks += 5;
    if (bus.address !== 8'h00) begin errors++; $display("[TB] FAIL rst_address got %h required 00", bus.address); end
    if (bus.addr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_addr_valid got %b required 0", bus.addr_valid); end
    if (bus.wrap !== 1'b0) begin errors++; $display("[TB] FAIL rst_wrap got %b required 0", bus.wrap); end
    if (bus.ftw_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready got %b required 0", bus.ftw_ready); end
    if (bus.ftw_active !== 24'h0) begin errors++; $display("[TB] FAIL rst_ftw_active got %h required 0", bus.ftw_active); end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.ftw_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_ready got %b required 1", bus.ftw_ready); end
  endtask

  task automatic test_immediate_run();
    load_now(24'h010000);
    bus.en = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      push_exp(8'(i), i == 256);
      tick();
      checks++;
      if (bus.addr_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL run_addr_valid step %0d got %b required 1", i, bus.addr_valid);
      end
    end
    bus.en = 1'b0;
    tick();
  endtask

  task automatic test_pending_wrap();
    load_now(24'h400000);
    bus.en            = 1'b1;
    bus.ftw_data      = 24'h100000;
    bus.ftw_immediate = 1'b0;
    bus.ftw_valid     = 1'b1;
    push_exp(8'h40, 1'b0);
    tick();
    bus.ftw_valid = 1'b0;
    checks++;
    if (bus.ftw_ready !== 1'b0) begin errors++; $display("[TB] FAIL pend_ready_drop got %b required 0", bus.ftw_ready); end
    for (int k = 2; k <= 4; k++) begin
      push_exp(8'((k * 'h40) & 'hFF), k == 4);
      tick();
      checks += 2;
      if (bus.ftw_ready !== (k == 4)) begin
        errors++;
        $display("[TB] FAIL pend_ready step %0d got %b required %b", k, bus.ftw_ready, (k == 4));
      end
      if (bus.ftw_active !== ((k == 4) ? 24'h100000 : 24'h400000)) begin
        errors++;
        $display("[TB] FAIL pend_ftw_active step %0d got %h", k, bus.ftw_active);
      end
    end
    for (int k = 1; k <= 4; k++) begin
      push_exp(8'(k * 'h10), 1'b0);
      tick();
    end
    bus.en = 1'b0;
    tick();
  endtask

  task automatic test_phase_clr();
    load_now(24'h010000);
    bus.phase_off = 8'h40;
    bus.en        = 1'b1;
    bus.phase_clr = 1'b1;
    push_exp(8'h40, 1'b0);
    tick();
    bus.phase_clr = 1'b0;
    checks += 2;
    if (bus.wrap !== 1'b0) begin errors++; $display("[TB] FAIL clr_wrap got %b required 0", bus.wrap); end
    if (bus.address !== 8'h40) begin errors++; $display("[TB] FAIL clr_address got %h required 40", bus.address); end
    for (int k = 1; k <= 3; k++) begin
      push_exp(8'('h40 + k), 1'b0);
      tick();
    end
    bus.phase_off = 8'hFE;
    push_exp(8'h02, 1'b0);
    tick();
    push_exp(8'h03, 1'b0);
    tick();
    bus.en        = 1'b0;
    bus.phase_off = 8'h00;
    tick();
    checks++;
    if (bus.address !== 8'h03) begin errors++; $display("[TB] FAIL clr_hold_address got %h required 03", bus.address); end
  endtask

  task automatic test_enable_hold();
    bus.en            = 1'b1;
    bus.ftw_data      = 24'h020000;
    bus.ftw_immediate = 1'b0;
    bus.ftw_valid     = 1'b1;
    push_exp(8'h06, 1'b0);
    tick();
    bus.ftw_valid = 1'b0;
    push_exp(8'h07, 1'b0);
    tick();
    checks++;
    if (bus.ftw_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_ready_pend got %b required 0", bus.ftw_ready); end
    bus.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks += 4;
      if (bus.addr_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_addr_valid got %b required 0", bus.addr_valid); end
      if (bus.wrap !== 1'b0) begin errors++; $display("[TB] FAIL hold_wrap got %b required 0", bus.wrap); end
      if (bus.address !== 8'h07) begin errors++; $display("[TB] FAIL hold_address got %h required 07", bus.address); end
      if (bus.ftw_active !== 24'h020000) begin errors++; $display("[TB] FAIL hold_ftw_active got %h required 020000", bus.ftw_active); end
    end
    checks++;
    if (bus.ftw_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_ready_idle got %b required 1", bus.ftw_ready); end
    bus.en = 1'b1;
    push_exp(8'h09, 1'b0);
    tick();
    push_exp(8'h0B, 1'b0);
    tick();
    bus.en = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    load_now(24'h400000);
    bus.en            = 1'b1;
    bus.ftw_data      = 24'h200000;
    bus.ftw_immediate = 1'b0;
    bus.ftw_valid     = 1'b1;
    push_exp(8'h4B, 1'b0);
    tick();
    bus.ftw_data = 24'h080000;
    push_exp(8'h8B, 1'b0);
    tick();
    checks += 2;
    if (bus.ftw_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_blocked got %b required 0", bus.ftw_ready); end
    if (bus.ftw_active !== 24'h400000) begin errors++; $display("[TB] FAIL b2b_ftw_old got %h required 400000", bus.ftw_active); end
    push_exp(8'hCB, 1'b0);
    tick();
    push_exp(8'h0B, 1'b1);
    tick();
    checks += 2;
    if (bus.ftw_active !== 24'h200000) begin errors++; $display("[TB] FAIL b2b_ftw_first got %h required 200000", bus.ftw_active); end
    if (bus.ftw_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_reopen got %b required 1", bus.ftw_ready); end
    push_exp(8'h2B, 1'b0);
    tick();
    bus.ftw_valid = 1'b0;
    checks += 2;
    if (bus.ftw_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_second got %b required 0", bus.ftw_ready); end
    if (bus.ftw_active !== 24'h200000) begin errors++; $display("[TB] FAIL b2b_ftw_hold got %h required 200000", bus.ftw_active); end
    for (int k = 1; k <= 6; k++) begin
      push_exp(8'('h2B + k * 'h20), 1'b0);
      tick();
    end
    push_exp(8'h0B, 1'b1);
    tick();
    checks++;
    if (bus.ftw_active !== 24'h080000) begin errors++; $display("[TB] FAIL b2b_ftw_second got %h required 080000", bus.ftw_active); end
    push_exp(8'h13, 1'b0);
    tick();
    bus.en = 1'b0;
    tick();
  endtask

  task automatic test_reset_queued();
    bus.en            = 1'b1;
    bus.ftw_data      = 24'h010000;
    bus.ftw_immediate = 1'b0;
    bus.ftw_valid     = 1'b1;
    push_exp(8'h1B, 1'b0);
    tick();
    bus.ftw_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    checks += 5;
    if (bus.address !== 8'h00) begin errors++; $display("[TB] FAIL rq_address got %h required 00", bus.address); end
    if (bus.addr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rq_addr_valid got %b required 0", bus.addr_valid); end
    if (bus.wrap !== 1'b0) begin errors++; $display("[TB] FAIL rq_wrap got %b required 0", bus.wrap); end
    if (bus.ftw_ready !== 1'b0) begin errors++; $display("[TB] FAIL rq_ready got %b required 0", bus.ftw_ready); end
    if (bus.ftw_active !== 24'h0) begin errors++; $display("[TB] FAIL rq_ftw_active got %h required 0", bus.ftw_active); end
    rst_n  = 1'b1;
    bus.en = 1'b0;
    tick();
    checks += 2;
    if (bus.ftw_ready !== 1'b1) begin errors++; $display("[TB] FAIL rq_ready_release got %b required 1", bus.ftw_ready); end
    if (bus.ftw_active !== 24'h0) begin errors++; $display("[TB] FAIL rq_ftw_lost got %h required 0", bus.ftw_active); end
    bus.en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_exp(8'h00, 1'b0);
      tick();
      checks++;
      if (bus.wrap !== 1'b0) begin errors++; $display("[TB] FAIL rq_static_wrap got %b required 0", bus.wrap); end
    end
    bus.en = 1'b0;
    tick();
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst_n             = 1'b0;
    bus.en            = 1'b0;
    bus.phase_clr     = 1'b0;
    bus.ftw_data      = '0;
    bus.ftw_immediate = 1'b0;
    bus.ftw_valid     = 1'b0;
    bus.phase_off     = '0;

    test_reset();
    test_immediate_run();
    test_pending_wrap();
    test_phase_clr();
    test_enable_hold();
    test_back_to_back();
    test_reset_queued();

    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d left required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
